// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - packs RV32I fields into instruction words behind a 2-entry output buffer
// Optional range checking with NOP substitution is enabled by defining ENCODER_RANGE_CHECK_EN.
module instr_encoder #(
    parameter int ADDR_W = 10
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [2:0]        i_fmt,
    input  logic [6:0]        i_opcode,
    input  logic [4:0]        i_rd,
    input  logic [4:0]        i_rs1,
    input  logic [4:0]        i_rs2,
    input  logic [2:0]        i_funct3,
    input  logic [6:0]        i_funct7,
    input  logic [31:0]       i_imm,
    input  logic              i_addr_clr,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [31:0]       o_instr,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_err,
    output logic [7:0]        o_err_cnt
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]       enc_word;
    logic [31:0]       push_word;
    logic              push_err;
    logic [1:0]        count;
    logic [ADDR_W-1:0] addr_cnt;
    logic [31:0]       tail_instr;
    logic [ADDR_W-1:0] tail_addr;
    logic              tail_err;
    logic              push;
    logic              pop;

    // Scatter the immediate into the positions the decode-side generator gathers from
    always_comb begin
        enc_word = '0;
        case (i_fmt)
            3'd0: enc_word = {i_imm[31:12], i_rd, i_opcode};
            3'd1: enc_word = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
            3'd2: enc_word = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
            3'd3: enc_word = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                              i_imm[4:1], i_imm[11], i_opcode};
            3'd4: enc_word = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
            3'd5: enc_word = {i_funct7, i_imm[4:0], i_rs1, i_funct3, i_rd, i_opcode};
            default: enc_word = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
        endcase
    end

`ifdef ENCODER_RANGE_CHECK_EN
    logic       bad;
    logic [7:0] err_cnt;

    // An immediate is legal only if the bits dropped by truncation are pure sign extension
    always_comb begin
        bad = 1'b0;
        case (i_fmt)
            3'd0: bad = |i_imm[11:0];
            3'd1: bad = i_imm[0] | ~((&i_imm[31:20]) | ~(|i_imm[31:20]));
            3'd2: bad = ~((&i_imm[31:11]) | ~(|i_imm[31:11]));
            3'd3: bad = i_imm[0] | ~((&i_imm[31:12]) | ~(|i_imm[31:12]));
            3'd4: bad = ~((&i_imm[31:11]) | ~(|i_imm[31:11]));
            3'd5: bad = |i_imm[31:5];
            3'd6: bad = 1'b0;
            default: bad = 1'b1;
        endcase
    end

    assign push_word = bad ? NOP : enc_word;
    assign push_err  = bad;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            err_cnt <= '0;
        end else if (push && push_err && err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end

    assign o_err_cnt = err_cnt;
`else
    assign push_word = enc_word;
    assign push_err  = 1'b0;
    assign o_err_cnt = 8'd0;
`endif

    assign o_ready = (count != 2'd2);
    assign o_valid = (count != 2'd0);
    assign push    = i_valid & o_ready;
    assign pop     = o_valid & i_ready;

    // Head entry drives the outputs directly; the tail only fills when the head is stalled
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count      <= '0;
            addr_cnt   <= '0;
            o_instr    <= '0;
            o_addr     <= '0;
            o_err      <= 1'b0;
            tail_instr <= '0;
            tail_addr  <= '0;
            tail_err   <= 1'b0;
        end else begin
            if (i_addr_clr) begin
                addr_cnt <= '0;
            end else if (push) begin
                addr_cnt <= addr_cnt + ADDR_W'(1);
            end

            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        o_instr <= push_word;
                        o_addr  <= addr_cnt;
                        o_err   <= push_err;
                    end else begin
                        tail_instr <= push_word;
                        tail_addr  <= addr_cnt;
                        tail_err   <= push_err;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    if (count == 2'd2) begin
                        o_instr <= tail_instr;
                        o_addr  <= tail_addr;
                        o_err   <= tail_err;
                    end
                    count <= count - 2'd1;
                end
                2'b11: begin
                    o_instr <= push_word;
                    o_addr  <= addr_cnt;
                    o_err   <= push_err;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Inverse of the immediate generator. It packs instruction fields (format, opcode, registers, funct fields and a 32-bit immediate) into a legal 32-bit RV32I instruction word. It scatters the immediate bits into the positions the decode-stage immediate generator gathers them from. It sits between the debug/boot loader and instruction memory, streams encoded words through a 2-entry output buffer with a valid/ready handshake, and tags each word with a sequential word address.

## Interface
- ADDR_W, 10: width of word-address counter/tag
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_valid  in  1  input fields valid
- o_ready  out  1  encoder can accept (buffer not full)
- i_fmt  in  3  0=U, 1=J, 2=I, 3=B, 4=S, 5=SHIFT, 6=R, 7=reserved
- i_opcode  in  7  instr[6:0]
- i_rd, i_rs1, i_rs2  in  5 each  register fields
- i_funct3  in  3  instr[14:12]
- i_funct7  in  7  instr[31:25] for R and SHIFT
- i_imm  in  32  immediate value (byte offset for B/J, full value for U)
- i_addr_clr  in  1  synchronous clear of address counter
- o_valid  out  1  head word valid
- i_ready  in  1  downstream accepts head word
- o_instr  out  32  encoded instruction word
- o_addr  out  ADDR_W  word address tag of head entry
- o_err  out  1  head word failed range check (replaced by NOP)
- o_err_cnt  out  8  saturating count of errored words accepted

## Operation
- Field placement: U {imm[31:12],rd,op}; J {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}; I {imm[11:0],rs1,f3,rd,op}; B {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}; S {imm[11:5],rs2,rs1,f3,imm[4:0],op}; SHIFT {f7,imm[4:0],rs1,f3,rd,op}; R {f7,rs2,rs1,f3,rd,op}.
- Range rules: I/S: imm[31:11] all equal; B: imm[31:12] all equal and imm[0]=0; J: imm[31:20] all equal and imm[0]=0; U: imm[11:0]=0; SHIFT: imm[31:5]=0; R: imm ignored; fmt 7 always errors.
- Errored word: stored as 32'h0000_0013 (ADDI x0,x0,0) with err bit set; address still consumed.
- Push: i_valid & o_ready. The encoded word, error bit and address counter value are written into the 2-entry FIFO. The counter then increments and wraps from 2^ADDR_W-1 to 0.
- Pop: o_valid & i_ready.
- o_ready = (count < 2). It depends only on registered count, with no combinational path from i_ready.
- Simultaneous push and pop at count 1: count stays 1, order preserved.
- i_addr_clr with a push in the same cycle: the pushed word takes the current counter value, and the counter becomes 0.
- o_err_cnt increments on push of an errored word and saturates at 255.
- o_instr, o_addr and o_err come from the head register and are held stable while o_valid & ~i_ready.

## Timing
- Reset (async assert, sync release): FIFO empty. o_valid=0, o_ready=1, o_instr=0, o_addr=0, o_err=0, o_err_cnt=0, address counter=0.
- Latency: field push at edge N yields o_valid=1 with that word after edge N.
- Throughput: 1 word/cycle when i_ready is held high.
- Full (count=2): o_ready=0, and a pop at edge N raises o_ready after edge N.
- Reset mid-stream discards buffered words and does not count them.

## Configuration
- ENCODER_RANGE_CHECK_EN defined: range rules enforced, NOP substitution, o_err and o_err_cnt active.
- ENCODER_RANGE_CHECK_EN undefined: no checks. Immediates are truncated into the fields as placed, fmt 7 encodes as R, and o_err and o_err_cnt are tied to 0.

## Test plan
- Reset with no stimulus -> o_valid=0, o_ready=1, all outputs 0. Assert i_rst_n low mid-stream -> same values immediately.
- Push I fmt, op=0010011, rd=1, rs1=0, f3=0, imm=-1 -> o_instr=32'hFFF0_0093, o_addr=0, o_err=0 one cycle later.
- Push B fmt, op=1100011, rs1=1, rs2=2, f3=0, imm=-4 -> 32'hFE20_8EE3. Push J, rd=0, op=1101111, imm=8 -> 32'h0080_006F. Each word must pass through the immediate generator and return the original imm.
- Push I fmt imm=2048, then B fmt imm=3 -> two NOP words with o_err=1 and o_err_cnt=2. With the macro undefined -> truncated encodings and o_err=0.
- Hold i_ready=0 and push 3 words -> o_ready drops after the 2nd push and the 3rd is stalled. Release i_ready -> addresses 0,1,2 in order, no loss or duplication.
- Set ADDR_W=2, push 5 words with i_addr_clr pulsed on the 4th -> address sequence 0,1,2,3,0.
